// File: rtl/display_scan_ctrl.sv
// Avalon-MM 7-segment scan controller: shadow/display double buffer, one shared
// hex decoder, per-digit blanking and PWM brightness, registered pin outputs.
module display_scan_ctrl #(
    parameter int NDIGITS        = 4,
    parameter int PRESCALE       = 50000,
    parameter bit INVERT         = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chipselect,
    input  logic [1:0]         address,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic [6:0]         seg,
    output logic [NDIGITS-1:0] dig,
    output logic               frame_tick
);

    localparam int SUB_N = PRESCALE / 16;
    localparam int SUB_W = (SUB_N > 1) ? $clog2(SUB_N) : 1;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int DW    = 4 * NDIGITS;

    localparam logic [SUB_W-1:0]   SUB_MAX = SUB_W'(SUB_N - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(NDIGITS - 1);
    localparam logic [6:0]         SEG_OFF = {7{INVERT}};
    localparam logic [NDIGITS-1:0] DIG_OFF = {NDIGITS{DIG_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_CTRL   = 2'd1,
        REG_BRIGHT = 2'd2,
        REG_STATUS = 2'd3
    } reg_addr_t;

    logic [DW-1:0]      shadow;
    logic [DW-1:0]      buffer;
    logic               enable;
    logic [NDIGITS-1:0] blank;
    logic [3:0]         duty;
    logic [SUB_W-1:0]   sub;
    logic [3:0]         phase;
    logic [IDX_W-1:0]   idx;

    logic               wr_en;
    logic               rd_en;
    logic               sub_wrap;
    logic               frame_end;
    logic               lit;
    logic [3:0]         nibble;
    logic [6:0]         seg_on;
    logic [NDIGITS-1:0] dig_on;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h67;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign wr_en        = chipselect & write;
    assign rd_en        = chipselect & read;
    assign unused_wdata = ^writedata;

    assign sub_wrap  = (sub == SUB_MAX);
    assign frame_end = enable && sub_wrap && (phase == 4'hF) && (idx == IDX_MAX);

    // The very first clock of every slot stays dark so the previous digit's
    // segments never bleed into the newly selected digit.
    assign lit    = enable && !blank[idx] && (phase <= duty) && !((sub == '0) && (phase == 4'd0));
    assign nibble = buffer[4*idx +: 4];
    assign seg_on = lit ? hex_to_seg(nibble) : 7'h00;
    assign dig_on = lit ? (NDIGITS'(1) << idx) : '0;

    always_comb begin
        // NOTE: default every always_comb output first; a path that skips an
        // assignment would otherwise infer a latch.
        rd_mux = '0;
        case (reg_addr_t'(address))
            REG_DATA:   rd_mux[DW-1:0] = shadow;
            REG_CTRL: begin
                rd_mux[0]            = enable;
                rd_mux[8 +: NDIGITS] = blank;
            end
            REG_BRIGHT: rd_mux[3:0] = duty;
            REG_STATUS: begin
                rd_mux[2:0] = 3'(idx);
                rd_mux[8]   = enable;
            end
            default:    rd_mux = '0;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; the buffer copy relies on this to take the
    // shadow as it was before a write landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow     <= '0;
            buffer     <= '0;
            enable     <= 1'b0;
            blank      <= '0;
            duty       <= 4'hF;
            sub        <= '0;
            phase      <= 4'd0;
            idx        <= '0;
            frame_tick <= 1'b0;
            readdata   <= '0;
            seg        <= SEG_OFF;
            dig        <= DIG_OFF;
        end else begin
            if (!enable) begin
                sub   <= '0;
                phase <= 4'd0;
                idx   <= '0;
            end else if (sub_wrap) begin
                sub <= '0;
                if (phase == 4'hF) begin
                    phase <= 4'd0;
                    idx   <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
                end else begin
                    phase <= phase + 4'd1;
                end
            end else begin
                sub <= sub + SUB_W'(1);
            end

            if (!enable || frame_end)
                buffer <= shadow;

            frame_tick <= frame_end;
            seg        <= seg_on ^ SEG_OFF;
            dig        <= dig_on ^ DIG_OFF;

            if (rd_en)
                readdata <= rd_mux;

            if (wr_en) begin
                case (reg_addr_t'(address))
                    REG_DATA:   shadow <= writedata[DW-1:0];
                    REG_CTRL: begin
                        enable <= writedata[0];
                        blank  <= writedata[8 +: NDIGITS];
                    end
                    REG_BRIGHT: duty <= writedata[3:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a time-indexed reference model feeds
// scoreboard queues for the pin outputs and for register reads.
module tb_display_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int PRE   = 32;
    localparam int FRAME = NDIG * PRE;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [6:0]  seg;
    logic [3:0]  dig;
    logic        frame_tick;

    int n_cmp = 0;
    int n_err = 0;
    int n_scan_fail_printed = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       ft;
    } scan_t;

    scan_t       exp_q[$];
    logic [31:0] rd_q[$];

    logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    display_scan_ctrl #(
        .NDIGITS(NDIG), .PRESCALE(PRE), .INVERT(1'b0), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .address(address),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .seg(seg), .dig(dig), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Reference model: m_t counts clocks since enable, so slot/phase come from
    // division rather than from chained counters.
    logic [15:0] m_shadow, m_buf;
    logic        m_en;
    logic [3:0]  m_blank, m_duty;
    int          m_t;
    int          m_off, m_slot, m_phase;
    logic        m_lit;
    scan_t       m_exp;
    logic [31:0] m_rd;

    always @(posedge clk) begin
        if (reset) begin
            m_shadow = '0; m_buf = '0; m_en = 1'b0; m_blank = '0; m_duty = 4'hF; m_t = 0;
            m_exp = '{seg: 7'h00, dig: 4'hF, ft: 1'b0};
        end else begin
            m_off   = m_t % PRE;
            m_slot  = (m_t / PRE) % NDIG;
            m_phase = m_off / (PRE / 16);
            m_lit   = m_en && !m_blank[m_slot] && (m_phase <= int'(m_duty)) && (m_off != 0);
            m_exp.seg = m_lit ? hex7[m_buf[m_slot*4 +: 4]] : 7'h00;
            m_exp.dig = m_lit ? ~(4'b0001 << m_slot) : 4'hF;
            m_exp.ft  = m_en && ((m_t % FRAME) == FRAME - 1);
            if (chipselect && read) begin
                m_rd = '0;
                case (address)
                    2'd0: m_rd[15:0] = m_shadow;
                    2'd1: begin m_rd[0] = m_en; m_rd[11:8] = m_blank; end
                    2'd2: m_rd[3:0] = m_duty;
                    default: begin m_rd[2:0] = 3'(m_slot); m_rd[8] = m_en; end
                endcase
                rd_q.push_back(m_rd);
            end
            if (!m_en || m_exp.ft) m_buf = m_shadow;
            m_t = m_en ? (m_t + 1) % FRAME : 0;
            if (chipselect && write) begin
                case (address)
                    2'd0: m_shadow = writedata[15:0];
                    2'd1: begin m_en = writedata[0]; m_blank = writedata[11:8]; end
                    2'd2: m_duty = writedata[3:0];
                    default: ;
                endcase
            end
        end
        exp_q.push_back(m_exp);
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            scan_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if ({seg, dig, frame_tick} !== e) begin
                n_err++;
                if (n_scan_fail_printed < 20) begin
                    n_scan_fail_printed++;
                    $display("FAIL scan_out @%0t: got seg=%h dig=%b ft=%b, want seg=%h dig=%b ft=%b",
                             $time, seg, dig, frame_tick, e.seg, e.dig, e.ft);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a, output logic [31:0] got, output logic [31:0] want);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        got  = readdata;
        want = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hxxxx_xxxx;
    endtask

    task automatic wait_ft(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 4 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_ft_timeout: got no frame_tick, want one within %0d clocks", tag, 4 * FRAME);
        end
    endtask

    // Observes one frame right after a frame_tick; records the seg seen per
    // digit, lit cycle counts, lit cycles past the duty window, and ticks.
    task automatic observe_frame(input int duty, output logic [6:0] segs [4], output int lit_cnt [4],
                                 output int late_lit, output int ft_cnt, output int ft_last);
        for (int d = 0; d < 4; d++) begin segs[d] = 7'hxx; lit_cnt[d] = 0; end
        late_lit = 0; ft_cnt = 0; ft_last = 0;
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (dig === ~(4'b0001 << d)) begin
                    segs[d] = seg;
                    lit_cnt[d]++;
                    if (((k - 1) % PRE) >= (duty + 1) * (PRE / 16)) late_lit++;
                end
            end
            if (frame_tick === 1'b1) begin ft_cnt++; ft_last = k; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] got, want;
        @(negedge clk);
        n_cmp++;
        if ({seg, dig, frame_tick, readdata} !== {7'h00, 4'hF, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_outputs: got seg=%h dig=%b ft=%b rd=%h, want 00/1111/0/0", seg, dig, frame_tick, readdata);
        end
        reset = 1'b0;
        do_read(2'd2, got, want);
        n_cmp++;
        if (got !== 32'h0000000F) begin n_err++; $display("FAIL reset_bright: got %h, want 0000000f", got); end
        n_cmp++;
        if (got !== want) begin n_err++; $display("FAIL reset_bright_model: got %h, want %h", got, want); end
        do_read(2'd0, got, want);
        n_cmp++;
        if (got !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h, want 00000000", got); end
    endtask

    task automatic test_registers();
        logic [31:0] got, want;
        do_write(2'd0, 32'hFFFF_FFFF);
        do_read(2'd0, got, want);
        n_cmp++;
        if (got !== 32'h0000_FFFF) begin n_err++; $display("FAIL data_unused_bits: got %h, want 0000ffff", got); end
        do_write(2'd1, 32'hFFFF_FFFF);
        do_read(2'd1, got, want);
        n_cmp++;
        if (got !== 32'h0000_0F01) begin n_err++; $display("FAIL ctrl_unused_bits: got %h, want 00000f01", got); end
        do_write(2'd1, 32'h0);
        do_write(2'd2, 32'hFFFF_FFF3);
        do_read(2'd2, got, want);
        n_cmp++;
        if (got !== 32'h0000_0003) begin n_err++; $display("FAIL bright_unused_bits: got %h, want 00000003", got); end
        do_write(2'd3, 32'hFFFF_FFFF);
        do_read(2'd3, got, want);
        n_cmp++;
        if (got !== 32'h0) begin n_err++; $display("FAIL status_ro: got %h, want 00000000", got); end
        do_write(2'd2, 32'hF);
        do_write(2'd0, 32'h0);
    endtask

    task automatic test_scan();
        logic [6:0] segs [4];
        int lit_cnt [4];
        int late, ftc, ftl;
        logic [31:0] got, want;
        logic [6:0] want_seg [4] = '{7'h71, 7'h6D, 7'h77, 7'h4F};
        do_write(2'd0, 32'h0000_3A5F);
        do_write(2'd1, 32'h0000_0001);
        wait_ft("scan");
        observe_frame(15, segs, lit_cnt, late, ftc, ftl);
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (segs[d] !== want_seg[d] || lit_cnt[d] != 31) begin
                n_err++;
                $display("FAIL scan_digit%0d: got seg=%h lit=%0d, want seg=%h lit=31", d, segs[d], lit_cnt[d], want_seg[d]);
            end
        end
        n_cmp++;
        if (ftc != 1 || ftl != FRAME) begin
            n_err++;
            $display("FAIL frame_tick_period: got %0d ticks last at %0d, want 1 at %0d", ftc, ftl, FRAME);
        end
        repeat (70) @(negedge clk);
        do_read(2'd3, got, want);
        n_cmp++;
        if (got !== want || got[8] !== 1'b1) begin
            n_err++;
            $display("FAIL status_running: got %h, want %h", got, want);
        end
    endtask

    task automatic test_brightness();
        logic [6:0] segs [4];
        int lit_cnt [4];
        int late, ftc, ftl;
        do_write(2'd2, 32'h3);
        wait_ft("bright");
        observe_frame(3, segs, lit_cnt, late, ftc, ftl);
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (lit_cnt[d] != 7) begin
                n_err++;
                $display("FAIL bright_lit_digit%0d: got %0d lit cycles, want 7", d, lit_cnt[d]);
            end
        end
        n_cmp++;
        if (late != 0) begin n_err++; $display("FAIL bright_window: got %0d lit cycles past duty, want 0", late); end
    endtask

    task automatic test_blank();
        logic [6:0] segs [4];
        int lit_cnt [4];
        int late, ftc, ftl;
        do_write(2'd1, 32'h0000_0401);
        wait_ft("blank");
        observe_frame(3, segs, lit_cnt, late, ftc, ftl);
        n_cmp++;
        if (lit_cnt[2] != 0) begin n_err++; $display("FAIL blank_digit2: got %0d lit cycles, want 0", lit_cnt[2]); end
        n_cmp++;
        if (lit_cnt[0] != 7 || lit_cnt[1] != 7 || lit_cnt[3] != 7 || segs[3] !== 7'h4F) begin
            n_err++;
            $display("FAIL blank_others: got lit %0d/%0d/%0d seg3=%h, want 7/7/7 seg3=4f", lit_cnt[0], lit_cnt[1], lit_cnt[3], segs[3]);
        end
    endtask

    task automatic test_data_update();
        logic [6:0] segs [4];
        int lit_cnt [4];
        int late, ftc, ftl, stale_bad;
        logic [31:0] got, want;
        logic [6:0] new_seg [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        logic [6:0] abcd_seg [4] = '{7'h5E, 7'h39, 7'h7C, 7'h77};
        do_write(2'd1, 32'h1);
        do_write(2'd2, 32'hF);
        wait_ft("update");
        repeat (40) @(negedge clk);
        do_write(2'd0, 32'h0000_1234);
        do_read(2'd0, got, want);
        n_cmp++;
        if (got !== 32'h0000_1234) begin n_err++; $display("FAIL data_readback: got %h, want 00001234", got); end
        stale_bad = 0;
        for (int i = 0; i < FRAME && frame_tick !== 1'b1; i++) begin
            @(negedge clk);
            if (dig === 4'b1011 && seg !== 7'h77) stale_bad++;
            if (dig === 4'b0111 && seg !== 7'h4F) stale_bad++;
        end
        n_cmp++;
        if (stale_bad != 0 || frame_tick !== 1'b1) begin
            n_err++;
            $display("FAIL data_before_frame: got %0d early updates ft=%b, want 0 and ft=1", stale_bad, frame_tick);
        end
        observe_frame(15, segs, lit_cnt, late, ftc, ftl);
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (segs[d] !== new_seg[d]) begin n_err++; $display("FAIL data_after_frame%0d: got %h, want %h", d, segs[d], new_seg[d]); end
        end
        repeat (FRAME - 1) @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'h0000_ABCD;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        n_cmp++;
        if (frame_tick !== 1'b1) begin n_err++; $display("FAIL aligned_write_tick: got ft=%b, want 1", frame_tick); end
        observe_frame(15, segs, lit_cnt, late, ftc, ftl);
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (segs[d] !== new_seg[d]) begin n_err++; $display("FAIL aligned_write_held%0d: got %h, want %h", d, segs[d], new_seg[d]); end
        end
        observe_frame(15, segs, lit_cnt, late, ftc, ftl);
        for (int d = 0; d < 4; d++) begin
            n_cmp++;
            if (segs[d] !== abcd_seg[d]) begin n_err++; $display("FAIL aligned_write_shown%0d: got %h, want %h", d, segs[d], abcd_seg[d]); end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [31:0] got, want;
        bit seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (dig === 4'b1011) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL reset_mid_wait: got no digit-2 slot, want one within %0d clocks", 2 * FRAME); end
        reset = 1'b1; chipselect = 1'b1; write = 1'b1; address = 2'd0; writedata = 32'h0000_FFFF;
        @(negedge clk);
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        n_cmp++;
        if ({seg, dig, frame_tick, readdata} !== {7'h00, 4'hF, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got seg=%h dig=%b ft=%b rd=%h, want 00/1111/0/0", seg, dig, frame_tick, readdata);
        end
        do_read(2'd3, got, want);
        n_cmp++;
        if (got !== 32'h0 || got !== want) begin n_err++; $display("FAIL reset_mid_status: got %h, want 00000000", got); end
        do_read(2'd0, got, want);
        n_cmp++;
        if (got !== 32'h0) begin n_err++; $display("FAIL reset_dominates_write: got %h, want 00000000", got); end
        do_read(2'd2, got, want);
        n_cmp++;
        if (got !== 32'hF) begin n_err++; $display("FAIL reset_mid_bright: got %h, want 0000000f", got); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_registers();
        test_scan();
        test_brightness();
        test_blank();
        test_data_update();
        test_reset_mid_scan();
        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
